// File: rtl/overlap_add.sv
// overlap_add: overlap-add reconstruction of inverse-transform frames into a hop-sized output stream.
module overlap_add #(
  parameter int FFT_SIZE     = 4096,
  parameter int HOP_SIZE     = 1024,
  parameter int SAMPLE_WIDTH = 16,
  parameter int SHIFT        = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  input  logic [SAMPLE_WIDTH-1:0] s_axis_tdata,
  output logic                    s_axis_tready,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic [SAMPLE_WIDTH-1:0] m_axis_tdata,
  input  logic                    m_axis_tready,
  output logic                    ola_busy,
  output logic                    frame_err
);
  localparam int AW = $clog2(FFT_SIZE);
  localparam int ACC_WIDTH = SAMPLE_WIDTH + $clog2(FFT_SIZE / HOP_SIZE);
  typedef enum logic [1:0] {CLEAR, ACCUM, DRAIN} state_t;
  state_t state, state_nxt;
  logic signed [ACC_WIDTH-1:0] acc [FFT_SIZE];
  logic [AW-1:0] base, index, out_idx, load_idx, rd_addr, wr_addr;
  logic signed [ACC_WIDTH-1:0] rd_data, wr_data, sh;
  logic [ACC_WIDTH-SAMPLE_WIDTH:0] hi;
  logic [SAMPLE_WIDTH-1:0] sat;
  logic s_fire, m_fire, last_in, end_frame, load, we;
  assign s_axis_tready = state == ACCUM;
  assign ola_busy      = !s_axis_tready;
  assign s_fire        = s_axis_tvalid && s_axis_tready;
  assign m_fire        = m_axis_tvalid && m_axis_tready;
  assign last_in       = index == AW'(FFT_SIZE - 1);
  assign end_frame     = s_fire && (s_axis_tlast || last_in);
  // The output register refills whenever it is empty or its non-final beat is taken.
  assign load          = state == DRAIN && (!m_axis_tvalid || (m_fire && !m_axis_tlast));
  assign load_idx      = m_fire ? out_idx + AW'(1) : out_idx;
  assign rd_addr       = state == DRAIN ? base + load_idx : base + index;
  assign rd_data       = acc[rd_addr];
  assign sh            = rd_data >>> SHIFT;
  assign hi            = sh[ACC_WIDTH-1:SAMPLE_WIDTH-1];
  assign sat           = (&hi || !(|hi)) ? sh[SAMPLE_WIDTH-1:0]
                       : {sh[ACC_WIDTH-1], {(SAMPLE_WIDTH-1){~sh[ACC_WIDTH-1]}}};
  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    wr_addr   = rd_addr;
    wr_data   = '0;
    if (state == CLEAR) begin
      we        = 1'b1;
      wr_addr   = index;
      state_nxt = last_in ? ACCUM : CLEAR;
    end else if (state == ACCUM) begin
      we        = s_fire;
      wr_data   = rd_data + ACC_WIDTH'($signed(s_axis_tdata));
      state_nxt = end_frame ? DRAIN : ACCUM;
    end else if (state == DRAIN) begin
      we        = m_fire;
      wr_addr   = base + out_idx;
      state_nxt = (m_fire && m_axis_tlast) ? ACCUM : DRAIN;
    end else begin
      state_nxt = CLEAR;
    end
  end
  always_ff @(posedge clk)
    if (we) acc[wr_addr] <= wr_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= CLEAR;
      base          <= '0;
      index         <= '0;
      out_idx       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      frame_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) index <= index + AW'(1);
      if (s_fire) begin
        index <= end_frame ? '0 : index + AW'(1);
        if (end_frame && (s_axis_tlast != last_in)) frame_err <= 1'b1;
      end
      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= sat;
        m_axis_tlast  <= load_idx == AW'(HOP_SIZE - 1);
        out_idx       <= load_idx;
      end else if (m_fire) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
        out_idx       <= '0;
        base          <= base + AW'(HOP_SIZE);
      end
    end
  end
endmodule

// File: tb/tb_overlap_add.sv
// tb_overlap_add: directed vector bench for overlap_add with FFT_SIZE=16, HOP_SIZE=4, SHIFT=2.
module tb_overlap_add;
  logic clk = 0, reset = 1;
  logic s_axis_tvalid = 0, s_axis_tlast = 0, s_axis_tready;
  logic [15:0] s_axis_tdata = '0;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready = 1;
  logic [15:0] m_axis_tdata;
  logic ola_busy, frame_err;
  int n_checks = 0, n_fail = 0;
  overlap_add #(.FFT_SIZE(16), .HOP_SIZE(4), .SAMPLE_WIDTH(16), .SHIFT(2)) dut (
    .clk(clk), .reset(reset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tdata(s_axis_tdata), .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tready(m_axis_tready),
    .ola_busy(ola_busy), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit rst;
    int val;
    int nbeats;
    bit tl;
    int exp_out;
    bit exp_err;
  } vec_t;
  vec_t vecs[16];
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic do_reset();
    int cnt = 0;
    bit vseen = 0;
    @(negedge clk);
    reset = 1;
    m_axis_tready = 1;
    s_axis_tvalid = 0;
    s_axis_tlast = 0;
    repeat (2) @(negedge clk);
    check("rst_tready", s_axis_tready, 0);
    check("rst_mvalid", m_axis_tvalid, 0);
    check("rst_mlast", m_axis_tlast, 0);
    check("rst_mdata", int'(m_axis_tdata), 0);
    check("rst_busy", ola_busy, 1);
    check("rst_err", frame_err, 0);
    reset = 0;
    while (!s_axis_tready && cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (m_axis_tvalid) vseen = 1;
    end
    check("clear_cycles", cnt, 16);
    check("clear_mvalid", vseen, 0);
  endtask
  task automatic send_frame(input int val, input int n, input bit tl);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (!s_axis_tready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!s_axis_tready) begin
        check("tready_timeout", 0, 1);
        break;
      end
      s_axis_tvalid = 1;
      s_axis_tdata  = 16'(val);
      s_axis_tlast  = tl && (i == n - 1);
      @(negedge clk);
    end
    s_axis_tvalid = 0;
    s_axis_tlast  = 0;
  endtask
  task automatic collect(input int exp, input bit stall);
    int beats = 0, cyc = 0, first = 0;
    bit pstall = 0;
    logic [15:0] pd = '0;
    logic pl = 0;
    while (beats < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (m_axis_tvalid && first == 0) first = cyc;
      if (pstall) begin
        check("hold_valid", m_axis_tvalid, 1);
        check("hold_data", int'(m_axis_tdata), int'(pd));
        check("hold_last", m_axis_tlast, pl);
      end
      m_axis_tready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (m_axis_tvalid && m_axis_tready) begin
        check("out_data", int'($signed(m_axis_tdata)), exp);
        check("out_last", m_axis_tlast, beats == 3);
        beats++;
      end
      pstall = m_axis_tvalid && !m_axis_tready;
      pd = m_axis_tdata;
      pl = m_axis_tlast;
    end
    check("drain_beats", beats, 4);
    check("first_valid_latency", (first >= 1 && first <= 3), 1);
  endtask
  initial begin
    vecs[0]  = '{1, 400, 16, 1, 100, 0};
    vecs[1]  = '{0, 400, 16, 1, 200, 0};
    vecs[2]  = '{0, 400, 16, 1, 300, 0};
    vecs[3]  = '{0, 400, 16, 1, 400, 0};
    vecs[4]  = '{0, 400, 16, 1, 400, 0};
    vecs[5]  = '{1, 32767, 16, 1, 8191, 0};
    vecs[6]  = '{0, 32767, 16, 1, 16383, 0};
    vecs[7]  = '{0, 32767, 16, 1, 24575, 0};
    vecs[8]  = '{0, 32767, 16, 1, 32767, 0};
    vecs[9]  = '{0, 32767, 16, 1, 32767, 0};
    vecs[10] = '{1, -32768, 16, 1, -8192, 0};
    vecs[11] = '{0, -32768, 16, 1, -16384, 0};
    vecs[12] = '{0, -32768, 16, 1, -24576, 0};
    vecs[13] = '{0, -32768, 16, 1, -32768, 0};
    vecs[14] = '{0, -32768, 16, 1, -32768, 0};
    vecs[15] = '{1, 400, 16, 0, 100, 1};
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].rst) do_reset();
      send_frame(vecs[i].val, vecs[i].nbeats, vecs[i].tl);
      collect(vecs[i].exp_out, 0);
      check($sformatf("frame_err_v%0d", i), frame_err, vecs[i].exp_err);
    end
    // Short frame ends early, random backpressure on both hops.
    do_reset();
    send_frame(400, 8, 1);
    collect(100, 1);
    check("short_frame_err", frame_err, 1);
    send_frame(400, 16, 1);
    collect(200, 1);
    check("err_sticky", frame_err, 1);
    // Reset in the middle of a drain.
    do_reset();
    send_frame(400, 16, 1);
    m_axis_tready = 1;
    begin
      int t = 0;
      while (!m_axis_tvalid && t < 20) begin
        @(negedge clk);
        t++;
      end
      check("pre_reset_valid", m_axis_tvalid, 1);
    end
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("mid_drain_rst_valid", m_axis_tvalid, 0);
    check("mid_drain_rst_busy", ola_busy, 1);
    do_reset();
    send_frame(400, 16, 1);
    collect(100, 0);
    check("post_reset_err", frame_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
